// File: rtl/pc_cmd_decoder_pkg.sv
// Shared encodings for the PC command decoder: mode nibbles, error-bit
// positions and the decoder FSM state type.
package pc_cmd_decoder_pkg;

    localparam logic [3:0] MODE_READ1  = 4'b0001;
    localparam logic [3:0] MODE_READ2  = 4'b0010;
    localparam logic [3:0] MODE_WRITE1 = 4'b0100;
    localparam logic [3:0] MODE_WRITE2 = 4'b1000;

    // Bit positions inside error_code = {framing, overrun, timeout, bad_mode}.
    localparam int ERR_BAD_MODE = 0;
    localparam int ERR_TIMEOUT  = 1;
    localparam int ERR_OVERRUN  = 2;
    localparam int ERR_FRAMING  = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_DATA_HI = 3'd2,
        ST_DATA_LO = 3'd3,
        ST_ISSUE   = 3'd4
    } state_e;

    function automatic logic is_valid_mode(input logic [7:0] mode_byte);
        return (mode_byte[7:4] == 4'h0) &&
               ((mode_byte[3:0] == MODE_READ1)  || (mode_byte[3:0] == MODE_READ2) ||
                (mode_byte[3:0] == MODE_WRITE1) || (mode_byte[3:0] == MODE_WRITE2));
    endfunction

endpackage

// File: rtl/pc_cmd_decoder_gap.sv
// Inter-byte gap timer: counts idle cycles since the last clear and flags the
// terminal count, holding there until cleared again.
module gap_timer #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    output logic tc_o
);

    localparam int             CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0]  LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q, count_d;

    assign tc_o = (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (!tc_o) begin
            count_d = count_q + CW'(1);
        end
    end

    // NOTE: sequential state is only ever updated with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pc_cmd_decoder.sv
// Assembles UART bytes into I2C instructions (mode, address, optional data)
// and reports discarded bytes/packets through a one-cycle error pulse.
module pc_cmd_decoder
    import pc_cmd_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_error,
    input  logic        i2c_ready,
    input  logic        full_i2cbuffer,
    output logic        instr_valid,
    output logic [7:0]  instr_mode,
    output logic [7:0]  instr_address,
    output logic [15:0] instr_wdata,
    output logic        cmd_error,
    output logic [3:0]  error_code
);

    state_e      state_q, state_d;
    logic        valid_q, valid_d;
    logic [3:0]  mode_q, mode_d;
    logic [7:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [3:0]  err_q, err_d;
    logic        cmd_error_q;
    logic        in_packet;
    logic        gap_tc;

    assign in_packet = (state_q == ST_ADDR) || (state_q == ST_DATA_HI) ||
                       (state_q == ST_DATA_LO);

    gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk    (clk),
        .reset  (reset),
        .clear_i(rx_valid || !in_packet),
        .tc_o   (gap_tc)
    );

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_d = state_q;
        valid_d = valid_q;
        mode_d  = mode_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = '0;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (rx_error) begin
                        err_d[ERR_FRAMING] = 1'b1;
                    end else if (is_valid_mode(rx_data)) begin
                        mode_d  = rx_data[3:0];
                        wdata_d = '0;
                        state_d = ST_ADDR;
                    end else begin
                        err_d[ERR_BAD_MODE] = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                if (rx_valid && !rx_error) begin
                    addr_d = rx_data;
                    if (mode_q == MODE_WRITE2) begin
                        state_d = ST_DATA_HI;
                    end else if (mode_q == MODE_WRITE1) begin
                        state_d = ST_DATA_LO;
                    end else begin
                        state_d = ST_ISSUE;
                        valid_d = 1'b1;
                    end
                end
            end
            ST_DATA_HI: begin
                if (rx_valid && !rx_error) begin
                    wdata_d[15:8] = rx_data;
                    state_d       = ST_DATA_LO;
                end
            end
            ST_DATA_LO: begin
                if (rx_valid && !rx_error) begin
                    wdata_d[7:0] = rx_data;
                    state_d      = ST_ISSUE;
                    valid_d      = 1'b1;
                end
            end
            ST_ISSUE: begin
                // Bytes arriving while an instruction is pending are dropped.
                if (rx_valid) begin
                    err_d[ERR_OVERRUN] = 1'b1;
                    err_d[ERR_FRAMING] = rx_error;
                end
                if (valid_q && i2c_ready && !full_i2cbuffer) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase

        // Mid-packet aborts override whatever the state branch decided.
        if (in_packet && rx_valid && rx_error) begin
            state_d            = ST_IDLE;
            err_d[ERR_FRAMING] = 1'b1;
        end else if (in_packet && !rx_valid && gap_tc) begin
            state_d            = ST_IDLE;
            err_d[ERR_TIMEOUT] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            valid_q     <= 1'b0;
            mode_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            err_q       <= '0;
            cmd_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            mode_q      <= mode_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            cmd_error_q <= |err_d;
        end
    end

    assign instr_valid   = valid_q;
    assign instr_mode    = {4'b0000, mode_q};
    assign instr_address = addr_q;
    assign instr_wdata   = wdata_q;
    assign cmd_error     = cmd_error_q;
    assign error_code    = err_q;

endmodule

// File: tb/tb_pc_cmd_decoder.sv
// Directed and randomized bench for pc_cmd_decoder with TIMEOUT_CYCLES=16;
// expected instructions and error pulses come from the packet rules directly.
module tb_pc_cmd_decoder;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_error;
    logic        i2c_ready;
    logic        full_i2cbuffer;
    logic        instr_valid;
    logic [7:0]  instr_mode;
    logic [7:0]  instr_address;
    logic [15:0] instr_wdata;
    logic        cmd_error;
    logic [3:0]  error_code;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pc_cmd_decoder #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_error      (rx_error),
        .i2c_ready     (i2c_ready),
        .full_i2cbuffer(full_i2cbuffer),
        .instr_valid   (instr_valid),
        .instr_mode    (instr_mode),
        .instr_address (instr_address),
        .instr_wdata   (instr_wdata),
        .cmd_error     (cmd_error),
        .error_code    (error_code)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_err(input string tag, input logic [3:0] code);
        check({tag, ":cmd_error"}, 32'(cmd_error), 32'(code != 4'h0));
        check({tag, ":error_code"}, 32'(error_code), 32'(code));
    endtask

    task automatic check_zero(input string tag);
        check({tag, ":valid"}, 32'(instr_valid), 32'd0);
        check({tag, ":mode"}, 32'(instr_mode), 32'd0);
        check({tag, ":addr"}, 32'(instr_address), 32'd0);
        check({tag, ":wdata"}, 32'(instr_wdata), 32'd0);
        check_err(tag, 4'h0);
    endtask

    task automatic send(input logic [7:0] b, input logic err);
        rx_data  = b;
        rx_valid = 1'b1;
        rx_error = err;
        tick();
        rx_valid = 1'b0;
        rx_error = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    // Reference rules: packet length and write data follow from the mode byte.
    function automatic int pkt_len(input logic [7:0] m);
        case (m)
            8'h01, 8'h02: return 2;
            8'h04:        return 3;
            8'h08:        return 4;
            default:      return 0;
        endcase
    endfunction

    function automatic logic [15:0] exp_wdata(input logic [7:0] m, input logic [7:0] b2,
                                              input logic [7:0] b3);
        if (m == 8'h08) return {b2, b3};
        if (m == 8'h04) return {8'h00, b2};
        return 16'h0000;
    endfunction

    // stall_kind: 0 random stall, 1 buffer full, 2 controller not ready.
    // inj_k: hold cycle on which a stray byte is sent (-1 for none).
    task automatic run_packet(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3, input int gap_max,
                              input int hold, input int stall_kind, input int inj_k,
                              input logic [7:0] inj_byte, input logic inj_err);
        logic [7:0]  bytes [4];
        logic [15:0] wd;
        logic [3:0]  exp_code;
        int          n;
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
        n  = pkt_len(b0);
        wd = exp_wdata(b0, b2, b3);
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                int gap;
                gap = (gap_max == 0) ? 0 : int'($urandom_range(gap_max, 0));
                for (int g = 0; g < gap; g++) begin
                    check_err({tag, ":gap"}, 4'h0);
                    tick();
                end
            end
            send(bytes[i], 1'b0);
            check_err({tag, ":byte"}, 4'h0);
            if (i < n - 1) check({tag, ":early_valid"}, 32'(instr_valid), 32'd0);
        end
        exp_code = 4'h0;
        for (int k = 0; k < hold; k++) begin
            check({tag, ":valid"}, 32'(instr_valid), 32'd1);
            check({tag, ":mode"}, 32'(instr_mode), 32'(b0));
            check({tag, ":addr"}, 32'(instr_address), 32'(b1));
            check({tag, ":wdata"}, 32'(instr_wdata), 32'(wd));
            check_err({tag, ":hold"}, exp_code);
            if (k == hold - 1) begin
                i2c_ready = 1'b1; full_i2cbuffer = 1'b0;
            end else if (stall_kind == 1) begin
                i2c_ready = 1'b1; full_i2cbuffer = 1'b1;
            end else if (stall_kind == 2) begin
                i2c_ready = 1'b0; full_i2cbuffer = 1'b0;
            end else begin
                case ($urandom_range(2, 0))
                    0:       begin i2c_ready = 1'b0; full_i2cbuffer = 1'b0; end
                    1:       begin i2c_ready = 1'b0; full_i2cbuffer = 1'b1; end
                    default: begin i2c_ready = 1'b1; full_i2cbuffer = 1'b1; end
                endcase
            end
            if (k == inj_k) begin
                rx_valid = 1'b1; rx_data = inj_byte; rx_error = inj_err;
                exp_code = {inj_err, 3'b100};
            end else begin
                exp_code = 4'h0;
            end
            tick();
            rx_valid = 1'b0; rx_error = 1'b0;
        end
        check({tag, ":released"}, 32'(instr_valid), 32'd0);
        check_err({tag, ":release"}, exp_code);
        tick();
        check_err({tag, ":after"}, 4'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        logic [7:0] m;
        int         hold;
        reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; rx_error = 1'b0;
        i2c_ready = 1'b1; full_i2cbuffer = 1'b0;
        repeat (3) tick();
        check_zero("reset");
        reset = 1'b0;
        tick();
        check_zero("post_reset");

        run_packet("write2", 8'h08, 8'h3A, 8'h12, 8'h34, 0, 1, 0, -1, 8'h00, 1'b0);
        run_packet("read1_stall", 8'h01, 8'h05, 8'h00, 8'h00, 0, 11, 1, -1, 8'h00, 1'b0);

        send(8'h03, 1'b0);
        check_err("bad_mode", 4'b0001);
        tick();
        check_err("bad_mode_clear", 4'h0);
        run_packet("read2_overrun", 8'h02, 8'h07, 8'h00, 8'h00, 0, 3, 2, 0, 8'h55, 1'b0);

        send(8'h04, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            check_err("timeout", (i == TO + 1) ? 4'b0010 : 4'h0);
            tick();
        end
        run_packet("write1", 8'h04, 8'h10, 8'hAB, 8'h00, 0, 1, 0, -1, 8'h00, 1'b0);

        send(8'h04, 1'b0);
        send(8'h77, 1'b1);
        check_err("framing", 4'b1000);
        tick();
        check_err("framing_clear", 4'h0);
        run_packet("after_framing", 8'h01, 8'h22, 8'h00, 8'h00, 0, 1, 0, -1, 8'h00, 1'b0);

        send(8'h08, 1'b0);
        send(8'h3A, 1'b0);
        reset = 1'b1;
        tick();
        check_zero("reset_data_hi");
        reset = 1'b0;
        tick();
        check_zero("reset_data_hi_release");
        send(8'h12, 1'b0);
        check_err("reset_back_idle", 4'b0001);
        tick();

        i2c_ready = 1'b0;
        send(8'h02, 1'b0);
        send(8'h09, 1'b0);
        check("issue_before_reset", 32'(instr_valid), 32'd1);
        reset = 1'b1;
        tick();
        check_zero("reset_issue");
        reset = 1'b0;
        i2c_ready = 1'b1;
        tick();
        check_zero("reset_issue_release");

        for (int p = 0; p < 40; p++) begin
            if ($urandom_range(4, 0) == 0) begin
                do b = 8'($urandom); while (b inside {8'h01, 8'h02, 8'h04, 8'h08});
                send(b, 1'b0);
                check_err("rand_bad_mode", 4'b0001);
            end
            case ($urandom_range(3, 0))
                0:       m = 8'h01;
                1:       m = 8'h02;
                2:       m = 8'h04;
                default: m = 8'h08;
            endcase
            hold = int'($urandom_range(4, 1));
            run_packet("rand", m, 8'($urandom), 8'($urandom), 8'($urandom), 5, hold, 0,
                       ($urandom_range(3, 0) == 0) ? int'($urandom_range(hold - 1, 0)) : -1,
                       8'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_cmd_decoder.md
PC_CMD_DECODER -- requirements
Module: pc_cmd_decoder

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 100000, the maximum idle gap in cycles between bytes of one packet.
REQ-002 clk  in  1  clock.
REQ-003 reset  in  1  reset; synchronous, active-high.
REQ-004 rx_data  in  8  byte from UART receiver.
REQ-005 rx_valid  in  1  one-cycle strobe; rx_data is valid.
REQ-006 rx_error  in  1  one-cycle strobe; UART framing error on the current byte.
REQ-007 i2c_ready  in  1  I2C controller can accept an instruction.
REQ-008 full_i2cbuffer  in  1  result buffer full; issue is blocked.
REQ-009 instr_valid  out  1  instruction pending for the I2C controller.
REQ-010 instr_mode  out  8  {4'b0, one-hot op nibble}.
REQ-011 instr_address  out  8  I2C register address.
REQ-012 instr_wdata  out  16  write data, MSB first.
REQ-013 cmd_error  out  1  one-cycle pulse; a packet or byte was discarded.
REQ-014 error_code  out  4  {framing, overrun, timeout, bad_mode}; valid while cmd_error=1.

Function
REQ-015 Packet format:
- byte0 is the mode. Nibble 0001 = read1, 0010 = read2, 0100 = write1, 1000 = write2; the upper nibble SHALL be 0.
- byte1 is the address.
- write1 adds one data byte; write2 adds data_hi then data_lo.
REQ-016 FSM states are IDLE, ADDR, DATA_HI, DATA_LO and ISSUE.
REQ-017 IDLE transitions:
- Valid mode byte: go to ADDR.
- Any other mode byte: stay in IDLE and pulse cmd_error with bad_mode.
REQ-018 ADDR transitions:
- Reads go to ISSUE.
- write1 goes to DATA_LO.
- write2 goes to DATA_HI.
REQ-019 DATA_HI goes to DATA_LO, and DATA_LO goes to ISSUE.
REQ-020 Write data widths:
- write1 gives instr_wdata = {8'h00, byte2}.
- write2 gives {byte2, byte3}.
- Reads give 16'h0000.
REQ-021 instr_valid SHALL assert in the cycle after the rx_valid of the final packet byte (latency 1).
REQ-022 Transfer handshake:
- Transfer occurs on a cycle with instr_valid && i2c_ready && !full_i2cbuffer.
- instr_valid deasserts and the FSM returns to IDLE on the next cycle.
- All instr_* outputs SHALL hold stable while instr_valid=1.
REQ-023 In ISSUE, any rx_valid (including on the transfer cycle) SHALL drop the byte and pulse cmd_error with overrun; the pending instruction is unaffected.
REQ-024 Timeout:
- The gap counter clears on every accepted byte.
- In ADDR, DATA_HI or DATA_LO, once TIMEOUT_CYCLES cycles pass without rx_valid, the FSM SHALL discard the partial packet, go to IDLE and pulse timeout.
REQ-025 If rx_error coincides with rx_valid in any non-ISSUE state, the byte and any partial packet SHALL be discarded, the FSM goes to IDLE and pulses framing.
- rx_error in ISSUE is reported as framing|overrun.
REQ-026 Simultaneous error causes on one cycle SHALL set all applicable bits in a single pulse.
REQ-027 error_code SHALL be 4'b0 whenever cmd_error=0.

Reset
REQ-028 Reset SHALL force:
- FSM to IDLE and gap counter to 0.
- instr_valid=0, instr_mode=0, instr_address=0, instr_wdata=0, cmd_error=0, error_code=0.
REQ-029 Reset mid-packet or mid-ISSUE SHALL abandon the instruction with no error pulse.

Structure
REQ-030 The shared package SHALL hold:
- Mode nibble encodings (READ1, READ2, WRITE1, WRITE2).
- Error-bit index constants.
- The state enum.
REQ-031 There SHALL be one sub-module, gap_timer: a counter with a clear input and a terminal-count output, parameterised by TIMEOUT_CYCLES.
REQ-032 Registered outputs only, single clock domain.

Verification
REQ-033 The bench SHALL run with TIMEOUT_CYCLES=16 and cover these scenarios:
- Write2: send 08,3A,12,34 with i2c_ready=1. Expect instr_valid one cycle after byte 34 with mode=08, address=3A, wdata=1234, held for exactly 1 cycle.
- Read1 stalled: send 01,05 with full_i2cbuffer=1 for 10 cycles, then 0. Expect instr_valid held for 11 cycles with mode=01, address=05, wdata=0000, then IDLE.
- Bad mode: send 03. Expect cmd_error pulse, error_code=0001, FSM in IDLE. A following 02,07 SHALL issue read2 with address=07.
- Timeout: send 04, then idle for 20 cycles. Expect error_code=0010 at gap 16. A following 04,10,AB SHALL issue wdata=00AB.
- Overrun: during a held read2 (i2c_ready=0), send byte 55. Expect error_code=0100 and the pending instruction unchanged.
- Framing plus reset: rx_error with the second byte gives error_code=1000. Reset asserted during DATA_HI gives all outputs 0 and no error pulse.
